garegga_cen_gate: RTL and testbench

//  Sits directly downstream of the clock-enable generator, in the CLK96 domain. Gates every
//  CEN/CENB pair for pause and frame-step without orphaning half-cycles: once a CEN passes,
//  its CENB also passes before the channel freezes. Also counts pulses of one gated enable
//  per window so firmware and bench can check frequency (CEN4 -> 4000/ms).

---
 rtl/garegga_cen_gate.sv | 133 +++++++++++++
 tb/tb_garegga_cen_gate.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/garegga_cen_gate.sv
// Pause/frame-step gate for CEN/CENB pairs that never orphans a half-cycle, plus a per-window pulse monitor.
// Gated enables and PAUSED are registered: 1 CLK96 cycle after the raw enables; no backpressure.
module garegga_cen_gate #(
  parameter int N_CEN  = 6,
  parameter int WINDOW = 96000,
  parameter int CW     = 16
) (
  input  logic             CLK96,
  input  logic             RESETn,
  input  logic [N_CEN-1:0] CEN_IN,
  input  logic [N_CEN-1:0] CENB_IN,
  input  logic             PAUSE,
  input  logic             STEP,
  input  logic             VBLANK,
  input  logic [2:0]       MON_SEL,
  output logic [N_CEN-1:0] CEN_OUT,
  output logic [N_CEN-1:0] CENB_OUT,
  output logic             PAUSED,
  output logic [CW-1:0]    MON_COUNT,
  output logic             MON_VALID
);

  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_PAUSED, S_STEP} state_t;

  state_t           state_q, state_d;
  logic [N_CEN-1:0] ph_q, ph_d;
  logic [N_CEN-1:0] cen_pass, cenb_pass;
  logic [N_CEN-1:0] cen_out_q, cenb_out_q;
  logic             paused_q;
  logic             vblank_q;
  logic             vblank_rise;

  logic [WW-1:0]    win_q, win_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0]    mon_count_q, mon_count_d;
  logic             mon_valid_q, mon_valid_d;
  logic [2:0]       sel_q;
  logic             mon_pulse;

  assign vblank_rise = VBLANK & ~vblank_q;

  // ph tracks a CEN whose matching CENB has not yet gone out; a same-cycle pair leaves it as is.
  always_comb begin
    cen_pass  = '0;
    cenb_pass = '0;
    case (state_q)
      S_RUN, S_STEP: begin
        cen_pass  = CEN_IN;
        cenb_pass = CENB_IN;
      end
      S_DRAIN: cenb_pass = CENB_IN & ph_q;
      default: ;
    endcase
    ph_d = (ph_q & ~(cenb_pass & ~cen_pass)) | (cen_pass & ~cenb_pass);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:    if (PAUSE) state_d = S_DRAIN;
      S_DRAIN: begin
        if (!PAUSE)            state_d = S_RUN;
        else if (ph_q == '0)   state_d = S_PAUSED;
      end
      S_PAUSED: begin
        if (!PAUSE)            state_d = S_RUN;
        else if (STEP)         state_d = S_STEP;
      end
      S_STEP:   if (vblank_rise) state_d = S_DRAIN;
      default:  state_d = S_RUN;
    endcase
  end

  // Monitor samples the gated output, so a paused channel reports 0.
  always_comb begin
    mon_pulse = 1'b0;
    for (int i = 0; i < N_CEN; i++) begin
      if (int'(MON_SEL) == i) mon_pulse = cen_out_q[i];
    end
    cnt_inc     = (mon_pulse && (cnt_q != '1)) ? cnt_q + CW'(1) : cnt_q;
    win_d       = win_q + WW'(1);
    cnt_d       = cnt_inc;
    mon_count_d = mon_count_q;
    mon_valid_d = 1'b0;
    if (MON_SEL != sel_q) begin
      win_d = '0;
      cnt_d = '0;
    end else if (win_q == WIN_LAST) begin
      win_d       = '0;
      cnt_d       = CW'(mon_pulse);
      mon_count_d = cnt_inc;
      mon_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK96) begin
    if (!RESETn) begin
      state_q     <= S_RUN;
      ph_q        <= '0;
      cen_out_q   <= '0;
      cenb_out_q  <= '0;
      paused_q    <= 1'b0;
      vblank_q    <= 1'b0;
      win_q       <= '0;
      cnt_q       <= '0;
      mon_count_q <= '0;
      mon_valid_q <= 1'b0;
      sel_q       <= '0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      cen_out_q   <= cen_pass;
      cenb_out_q  <= cenb_pass;
      paused_q    <= (state_q == S_PAUSED);
      vblank_q    <= VBLANK;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      mon_count_q <= mon_count_d;
      mon_valid_q <= mon_valid_d;
      sel_q       <= MON_SEL;
    end
  end

  assign CEN_OUT   = cen_out_q;
  assign CENB_OUT  = cenb_out_q;
  assign PAUSED    = paused_q;
  assign MON_COUNT = mon_count_q;
  assign MON_VALID = mon_valid_q;

endmodule

// File: tb/tb_garegga_cen_gate.sv
// Directed bench for garegga_cen_gate; window shrunk to 960 cycles and CW to 8 so a 1-in-24 CEN
// gives 40 per window and a tied-high CEN saturates at 255.
module tb_garegga_cen_gate;

  localparam int N_CEN  = 6;
  localparam int WINDOW = 960;
  localparam int CW     = 8;

  logic             clk = 1'b0;
  logic             RESETn;
  logic [N_CEN-1:0] CEN_IN, CENB_IN;
  logic             PAUSE, STEP, VBLANK;
  logic [2:0]       MON_SEL;
  logic [N_CEN-1:0] CEN_OUT, CENB_OUT;
  logic             PAUSED;
  logic [CW-1:0]    MON_COUNT;
  logic             MON_VALID;

  always #5 clk = ~clk;

  garegga_cen_gate #(.N_CEN(N_CEN), .WINDOW(WINDOW), .CW(CW)) dut (
    .CLK96(clk), .RESETn(RESETn), .CEN_IN(CEN_IN), .CENB_IN(CENB_IN),
    .PAUSE(PAUSE), .STEP(STEP), .VBLANK(VBLANK), .MON_SEL(MON_SEL),
    .CEN_OUT(CEN_OUT), .CENB_OUT(CENB_OUT), .PAUSED(PAUSED),
    .MON_COUNT(MON_COUNT), .MON_VALID(MON_VALID)
  );

  int checks = 0;
  int failures = 0;

  int gen_ph = 0;
  bit gen_en = 1'b0;
  bit tie2 = 1'b0;
  bit chk_delay = 1'b0;
  int cen_cnt, cenb_cnt, any_cnt, paused_cnt, unpaused_cnt, strobes, delay_bad;
  logic [CW-1:0] last_mon;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cen_cnt = 0; cenb_cnt = 0; any_cnt = 0; paused_cnt = 0;
    unpaused_cnt = 0; strobes = 0; delay_bad = 0; last_mon = '0;
  endtask

  // One clock: drive channel 0 as CEN at phase 0 / CENB at phase 12 of 24, sample #1 after the edge.
  task automatic cyc();
    logic [N_CEN-1:0] cen_v, cenb_v;
    cen_v  = '0;
    cenb_v = '0;
    if (gen_en && gen_ph == 0)  cen_v[0]  = 1'b1;
    if (gen_en && gen_ph == 12) cenb_v[0] = 1'b1;
    cen_v[2] = tie2;
    CEN_IN  = cen_v;
    CENB_IN = cenb_v;
    @(posedge clk);
    #1;
    gen_ph = (gen_ph == 23) ? 0 : gen_ph + 1;
    if (CEN_OUT[0])  cen_cnt++;
    if (CENB_OUT[0]) cenb_cnt++;
    if (CEN_OUT != '0 || CENB_OUT != '0) any_cnt++;
    if (PAUSED) paused_cnt++; else unpaused_cnt++;
    if (chk_delay && (CEN_OUT !== cen_v || CENB_OUT !== cenb_v)) delay_bad++;
    if (MON_VALID) begin
      strobes++;
      last_mon = MON_COUNT;
    end
  endtask

  initial begin
    int n;
    int mid;
    RESETn = 1'b0; PAUSE = 1'b0; STEP = 1'b0; VBLANK = 1'b0; MON_SEL = 3'd0;
    CEN_IN = '0; CENB_IN = '0;
    clr();
    repeat (3) cyc();
    check_eq("rst_cen",    32'(CEN_OUT), 0);
    check_eq("rst_cenb",   32'(CENB_OUT), 0);
    check_eq("rst_paused", 32'(PAUSED), 0);
    check_eq("rst_count",  32'(MON_COUNT), 0);
    check_eq("rst_valid",  32'(MON_VALID), 0);

    // Free run, two full windows.
    RESETn = 1'b1; gen_en = 1'b1; gen_ph = 0;
    clr(); chk_delay = 1'b1; n = 0;
    while (strobes < 2 && n < 3000) begin cyc(); n++; end
    chk_delay = 1'b0;
    check_eq("run_strobes", 32'(strobes), 2);
    check_eq("run_count",   32'(last_mon), 40);
    check_eq("run_delay",   32'(delay_bad), 0);

    // Pause right after a CEN: the pending CENB drains, then PAUSED.
    while (gen_ph != 0) cyc();
    cyc();
    check_eq("cen_before_pause", 32'(CEN_OUT[0]), 1);
    PAUSE = 1'b1; clr(); n = 0;
    while (!PAUSED && n < 100) begin cyc(); n++; end
    check_eq("drain_paused", 32'(PAUSED), 1);
    check_eq("drain_cycles", 32'(n), 14);
    check_eq("drain_cen",    32'(cen_cnt), 0);
    check_eq("drain_cenb",   32'(cenb_cnt), 1);
    clr();
    repeat (10000) cyc();
    check_eq("pause_quiet",   32'(any_cnt), 0);
    check_eq("pause_held",    32'(unpaused_cnt), 0);
    check_eq("pause_strobes", 32'(strobes > 0), 1);
    check_eq("pause_mon",     32'(last_mon), 0);

    // Frame step of ~5000 cycles, with a stray second STEP in the middle.
    STEP = 1'b1; cyc(); STEP = 1'b0; cyc();
    check_eq("step_running", 32'(PAUSED), 0);
    clr();
    repeat (2500) cyc();
    STEP = 1'b1; cyc(); STEP = 1'b0;
    mid = cen_cnt;
    repeat (2499) cyc();
    check_eq("step_cen_range", 32'(cen_cnt >= 205 && cen_cnt <= 212), 1);
    check_eq("step_second_ignored", 32'((cen_cnt - mid) >= 100), 1);
    check_eq("step_no_pause", 32'(paused_cnt), 0);
    VBLANK = 1'b1; clr(); n = 0;
    while (!PAUSED && n < 100) begin cyc(); n++; end
    check_eq("step_end_paused", 32'(PAUSED), 1);
    check_eq("step_end_cen",    32'(cen_cnt <= 1), 1);
    VBLANK = 1'b0; cyc();

    // Unpause, re-enter DRAIN with a CENB pending, then release PAUSE mid-drain.
    PAUSE = 1'b0; cyc(); cyc();
    check_eq("unpause_run", 32'(PAUSED), 0);
    while (gen_ph != 0) cyc();
    cyc();
    PAUSE = 1'b1;
    repeat (4) cyc();
    check_eq("drain_pending", 32'(PAUSED), 0);
    PAUSE = 1'b0; clr();
    repeat (30) cyc();
    check_eq("resume_cen",  32'(cen_cnt), 1);
    check_eq("resume_cenb", 32'(cenb_cnt), 1);

    // Out-of-range MON_SEL restarts the window without a strobe and counts 0.
    MON_SEL = 3'd7; cyc();
    check_eq("sel_no_strobe", 32'(MON_VALID), 0);
    n = 0;
    while (!MON_VALID && n < 2000) begin cyc(); n++; end
    check_eq("sel_window_len", 32'(n), 960);
    check_eq("sel_oob_count",  32'(MON_COUNT), 0);

    // Tied-high CEN saturates the counter.
    tie2 = 1'b1; MON_SEL = 3'd2; clr(); n = 0;
    while (strobes < 2 && n < 3000) begin cyc(); n++; end
    check_eq("sat_strobes", 32'(strobes), 2);
    check_eq("sat_count",   32'(last_mon), 255);

    // Channel 2 now holds ph=1 with no CENB coming, so DRAIN cannot finish until reset.
    tie2 = 1'b0; PAUSE = 1'b1;
    repeat (5) cyc();
    check_eq("drain_stuck", 32'(PAUSED), 0);
    RESETn = 1'b0; cyc();
    check_eq("mid_rst_cen",    32'(CEN_OUT), 0);
    check_eq("mid_rst_cenb",   32'(CENB_OUT), 0);
    check_eq("mid_rst_paused", 32'(PAUSED), 0);
    check_eq("mid_rst_count",  32'(MON_COUNT), 0);
    check_eq("mid_rst_valid",  32'(MON_VALID), 0);
    PAUSE = 1'b0; RESETn = 1'b1; clr();
    repeat (30) cyc();
    check_eq("post_rst_cen",    32'(cen_cnt >= 1), 1);
    check_eq("post_rst_paused", 32'(paused_cnt), 0);
    PAUSE = 1'b1; n = 0;
    while (!PAUSED && n < 40) begin cyc(); n++; end
    check_eq("post_rst_ph_clear", 32'(PAUSED), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
